serial_tx: RTL
==============

Name: serial_tx

Overview:
UART transmitter (8N1, LSB first) that consumes the byte/strobe pair produced by message_printer and drives the FPGA TX pin.
- Inputs: tx_data / new_tx_data from message_printer.
- Feedback: returns tx_busy so message_printer only strobes when the line is free.
- Optional backpressure: the block input lets the host side (e.g. USB-serial CTS) hold off new frames.

Parameters:
- CLK_PER_BIT, 100, system clocks per UART bit (50 MHz / 500 kbaud); must be >= 2.
- CTR_SIZE, $clog2(CLK_PER_BIT), width of the bit-period counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- block  in  1  high = do not start new frames; a frame in progress completes.
- data  in  8  byte to send; sampled only in the accept cycle.
- new_data  in  1  single-cycle strobe requesting transmission of data.
- tx  out  1  serial line; idles high.
- busy  out  1  high = new_data will be ignored; connects to message_printer tx_busy.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE, tx=1, busy=0, counters=0.
  - Overrides everything, including a frame in progress; tx returns high on that edge.
- Block synchronisation: block is registered once as block_q; busy in IDLE equals block_q.
- States: IDLE -> START_BIT -> DATA -> STOP_BIT -> IDLE.
- Accept condition: state==IDLE && !block_q && new_data.
  - On accept: latch data into data_q, ctr=0, bit_ctr=0.
  - Next edge: state=START_BIT, tx=0, busy=1.
- new_data while busy (including while block_q=1): ignored, byte dropped, no queuing.
- Bit timing: ctr counts 0..CLK_PER_BIT-1; each level is held exactly CLK_PER_BIT cycles.
- START_BIT: tx=0; at ctr wrap, state=DATA.
- DATA:
  - tx=data_q[bit_ctr], LSB first.
  - At each ctr wrap, bit_ctr increments; after bit 7, state=STOP_BIT.
  - bit_ctr is 3 bits; it wraps 7->0 only on the transition to STOP_BIT.
- STOP_BIT: tx=1; at ctr wrap, state=IDLE.
- Frame length: 10*CLK_PER_BIT cycles from the first tx-low cycle to the first IDLE cycle.
- busy: 1 throughout START_BIT, DATA and STOP_BIT; in IDLE it equals block_q.
- Back-to-back: a new_data in the first IDLE cycle after STOP_BIT is accepted; no extra idle gap is inserted.
- block rising mid-frame: the current frame finishes; busy stays 1 in IDLE until block_q falls.
- block and new_data rising in the same cycle: new_data is accepted, because block_q is still 0.
- data changes after the accept cycle: no effect on the frame in progress (data_q is latched).

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined:
  - A PARITY_BIT state sits between DATA and STOP_BIT.
  - tx = ^data_q (even parity) for CLK_PER_BIT cycles.
  - Frame is 11*CLK_PER_BIT cycles; busy also covers PARITY_BIT.
- Undefined: no PARITY_BIT state; 8N1 framing exactly as above.

Decomposition:
- Shared package serial_pkg:
  - state encoding localparams: IDLE, START_BIT, DATA, PARITY_BIT, STOP_BIT;
  - STATE_SIZE = 3;
  - DEFAULT_CLK_PER_BIT = 100.
  - serial_rx reuses the package.
- One natural sub-module, serial_bit_timer:
  - parameterised by CLK_PER_BIT;
  - inputs clk, rst, clear; output tick = ctr==CLK_PER_BIT-1;
  - also reusable by serial_rx (half-bit sampling via a second parameter).

Test Plan:
(All scenarios use CLK_PER_BIT=4.)
1. Reset, then data=8'h31 ("1") with new_data for 1 cycle -> tx holds each of 0,1,0,0,0,1,1,0,0,1 for 4 cycles; busy=1 for 40 cycles, then 0.
2. Back-to-back: send 8'h30, then strobe 8'h41 on the first cycle busy==0 -> second start bit immediately follows the stop bit; no idle gap; both frames are bit-exact.
3. new_data strobed at cycle 10 of a frame with 8'hFF -> ignored; line shows only the first byte; tx stays 1 after the stop bit.
4. block=1 asserted mid-frame, new_data pulsed after the frame -> the frame completes; busy stays 1; no start bit until 1 cycle after block falls and a new strobe arrives.
5. rst=0 for 1 cycle at cycle 15 of a frame -> tx=1 and busy=0 on the next edge; a following 8'h55 strobe transmits a clean full frame.
6. With SERIAL_TX_PARITY_EN, send 8'h31 -> parity bit 1 after bit 7; frame 44 cycles. With 8'h33 -> parity bit 0.

Source files
------------

// File: rtl/serial_pkg.sv
// ============================================================================
// Module : serial_pkg
// Brief  : Shared state encoding and defaults for the serial_tx/serial_rx pair.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package serial_pkg;

    localparam int STATE_SIZE          = 3;
    localparam int DEFAULT_CLK_PER_BIT = 100;

    localparam logic [STATE_SIZE-1:0] IDLE       = 3'd0;
    localparam logic [STATE_SIZE-1:0] START_BIT  = 3'd1;
    localparam logic [STATE_SIZE-1:0] DATA       = 3'd2;
    localparam logic [STATE_SIZE-1:0] PARITY_BIT = 3'd3;
    localparam logic [STATE_SIZE-1:0] STOP_BIT   = 3'd4;

endpackage

`default_nettype wire

// File: rtl/serial_bit_timer.sv
// ============================================================================
// Module : serial_bit_timer
// Brief  : Bit-period counter, 0..CLK_PER_BIT-1, held at zero while clear is high.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module serial_bit_timer
    import serial_pkg::*;
#(
    parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
    parameter int TICK_AT     = CLK_PER_BIT - 1,
    parameter int CTR_SIZE    = $clog2(CLK_PER_BIT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    logic [CTR_SIZE-1:0] ctr_q;
    logic [CTR_SIZE-1:0] ctr_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ctr_q <= '0;
        end else begin
            ctr_q <= ctr_d;
        end
    end

    always_comb begin
        ctr_d = ctr_q + CTR_SIZE'(1);
        if (clear || (ctr_q == CTR_SIZE'(CLK_PER_BIT - 1))) begin
            ctr_d = '0;
        end
    end

    // A receiver can move TICK_AT to mid-bit for sampling; the wrap point is unchanged.
    assign tick = (ctr_q == CTR_SIZE'(TICK_AT));

endmodule

`default_nettype wire

// File: rtl/serial_tx.sv
// ============================================================================
// Module : serial_tx
// Brief  : UART transmitter, 8N1 LSB first, with host-side block input.
//          Define SERIAL_TX_PARITY_EN to insert an even-parity bit (8E1).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module serial_tx
    import serial_pkg::*;
#(
    parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
    parameter int CTR_SIZE    = $clog2(CLK_PER_BIT)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       block,
    input  logic [7:0] data,
    input  logic       new_data,
    output logic       tx,
    output logic       busy
);

    logic [STATE_SIZE-1:0] state_q;
    logic [STATE_SIZE-1:0] state_d;
    logic [7:0]            data_q;
    logic [7:0]            data_d;
    logic [2:0]            bit_ctr_q;
    logic [2:0]            bit_ctr_d;
    logic                  block_q;
    logic                  block_d;
    logic                  tx_q;
    logic                  tx_d;
    logic                  bit_tick;

    serial_bit_timer #(
        .CLK_PER_BIT (CLK_PER_BIT),
        .CTR_SIZE    (CTR_SIZE)
    ) u_bit_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q == IDLE),
        .tick  (bit_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            bit_ctr_q <= '0;
            block_q   <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            bit_ctr_q <= bit_ctr_d;
            block_q   <= block_d;
            tx_q      <= tx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        bit_ctr_d = bit_ctr_q;
        block_d   = block;
        case (state_q)
            IDLE: begin
                if (!block_q && new_data) begin
                    state_d   = START_BIT;
                    data_d    = data;
                    bit_ctr_d = 3'd0;
                end
            end
            START_BIT: begin
                if (bit_tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    bit_ctr_d = bit_ctr_q + 3'd1;
                    if (bit_ctr_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = PARITY_BIT;
`else
                        state_d = STOP_BIT;
`endif
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY_BIT: begin
                if (bit_tick) begin
                    state_d = STOP_BIT;
                end
            end
`endif
            STOP_BIT: begin
                if (bit_tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // tx is registered from next-state values so the pin never glitches.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START_BIT:  tx_d = 1'b0;
            DATA:       tx_d = data_d[bit_ctr_d];
            PARITY_BIT: tx_d = ^data_d;
            default:    tx_d = 1'b1;
        endcase
        busy = (state_q == IDLE) ? block_q : 1'b1;
    end

    assign tx = tx_q;

endmodule

`default_nettype wire
